// File: rtl/pipe_add_sub_pkg.sv
// pipe_add_sub_pkg: operation codes and the shared add/sub/saturate arithmetic
package pipe_add_sub_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADD_SAT, OP_SUB_SAT} op_e;
  localparam int MAX_W = 62;
  typedef logic [MAX_W+1:0] wide_t;
  // Operands arrive zero-extended; only their low w bits may be set.
  // Returns the flag in bit w+1 and the (w+1)-bit result in bits w:0.
  function automatic wide_t calc(input wide_t a, input wide_t b, input op_e op, input int w);
    wide_t lim, mask, sum, dif, data;
    logic ovf, brw, flag;
    lim = (wide_t'(1) << w) - wide_t'(1);
    mask = (wide_t'(1) << (w + 1)) - wide_t'(1);
    sum = a + b;
    dif = (a - b) & mask;
    ovf = sum > lim;
    brw = b > a;
    data = op == OP_ADD ? sum : op == OP_SUB ? dif : op == OP_ADD_SAT ? (ovf ? lim : sum) : (brw ? '0 : dif);
    flag = (op == OP_ADD || op == OP_ADD_SAT) ? ovf : brw;
    return (wide_t'(flag) << (w + 1)) | data;
  endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one elastic register slice that clears its payload when it drains empty
// Ports: clk, rst_n (sync, active-low); up_valid/up_ready/up_data toward the producer;
// dn_valid/dn_ready/dn_data toward the consumer.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);
  assign up_ready = !dn_valid || dn_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      dn_data  <= up_valid ? up_data : '0;
    end
  end
endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: elastic pipelined add/sub/saturating unit with tag pass-through
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_a/in_b/in_op/in_tag input handshake;
// out_valid/out_ready/out_data/out_flag/out_tag result handshake; occupancy = valid stage count.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [1:0]                    in_op,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH:0]                out_data,
  output logic                          out_flag,
  output logic [TAG_W-1:0]              out_tag,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);
  localparam int P = WIDTH + 2 + TAG_W;
  localparam int OCC_W = $clog2(STAGES + 1);
  logic [STAGES:0] vld, rdy;
  logic [P-1:0] pl [STAGES+1];
  logic [WIDTH+1:0] res;
  assign res = (WIDTH+2)'(calc(wide_t'(in_a), wide_t'(in_b), op_e'(in_op), WIDTH));
  assign vld[0] = in_valid;
  assign pl[0] = {res, in_tag};
  assign rdy[STAGES] = out_ready;
  // Stage 0 would report ready while its valid is held clear by reset; mask that.
  assign in_ready = rst_n && rdy[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_stage_reg #(.W(P)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[k]),
      .up_ready (rdy[k]),
      .up_data  (pl[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_data  (pl[k+1])
    );
  end
  assign out_valid = vld[STAGES];
  assign {out_flag, out_data, out_tag} = pl[STAGES];
  always_comb begin
    occupancy = '0;
    for (int i = 1; i <= STAGES; i++) occupancy += OCC_W'(vld[i]);
  end
endmodule
